// File: rtl/ec_point_adder_seq.sv
// Multi-cycle short-Weierstrass point adder/doubler over GF(P).
// A shared MSB-first modular multiplier and a binary extended-Euclid inverter are sequenced by one FSM.
module ec_point_adder_seq #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  P     = 8'd251,
  parameter logic [WIDTH-1:0]  A     = 8'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  input  logic [WIDTH-1:0] qx,
  input  logic [WIDTH-1:0] qy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rx,
  output logic [WIDTH-1:0] ry,
  output logic             err,
  output logic             busy
);

  localparam int unsigned IW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    MUL_LEN  = CW'(WIDTH);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CHECK = 4'd1;
  localparam logic [3:0] S_NUM_A = 4'd2;
  localparam logic [3:0] S_NUM_D = 4'd3;
  localparam logic [3:0] S_INV   = 4'd4;
  localparam logic [3:0] S_LAM   = 4'd5;
  localparam logic [3:0] S_X3    = 4'd6;
  localparam logic [3:0] S_Y3    = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [IW-1:0] s;
    s = {2'b00, a} + {2'b00, b};
    if (s >= {2'b00, P}) s = s - {2'b00, P};
    else                 s = s;
    return s[WIDTH-1:0];
  endfunction

  // Both branches are < P, so the wrap of the WIDTH-bit arithmetic is harmless.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    if (a >= b) d = a - b;
    else        d = a + P - b;
    return d;
  endfunction

  // x/2 mod P; for odd x this is (x+P)/2 = (x>>1) + (P>>1) + 1.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] h;
    if (x[0]) h = {1'b0, x[WIDTH-1:1]} + {1'b0, P[WIDTH-1:1]} + ONE;
    else      h = {1'b0, x[WIDTH-1:1]};
    return h;
  endfunction

  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  logic [WIDTH-1:0] num_q, num_d, lam_q, lam_d, x3_q, x3_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0] acc_q, acc_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
  logic             err_q, err_d;
  logic             out_valid_q, in_ready_q, busy_q;

  logic [WIDTH-1:0] mul_step_s, x3_s;
  logic             any_big_s, p_inf_s, q_inf_s, same_x_s;

  assign mul_step_s = mod_add(mod_add(acc_q, acc_q), mul_a_q[WIDTH-1] ? mul_b_q : ZERO);
  assign x3_s       = mod_sub(mod_sub(acc_q, px_q), qx_q);
  assign any_big_s  = (px_q >= P) || (py_q >= P) || (qx_q >= P) || (qy_q >= P);
  assign p_inf_s    = (px_q == ZERO) && (py_q == ZERO);
  assign q_inf_s    = (qx_q == ZERO) && (qy_q == ZERO);
  assign same_x_s   = (px_q == qx_q);

  // Next-state and datapath sequencing.
  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    num_d     = num_q;
    lam_d     = lam_q;
    x3_d      = x3_q;
    u_d       = u_q;
    v_d       = v_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    acc_d     = acc_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_cnt_d = mul_cnt_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          px_d    = px;
          py_d    = py;
          qx_d    = qx;
          qy_d    = qy;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (any_big_s) begin
          rx_d = ZERO; ry_d = ZERO; err_d = 1'b1; state_d = S_DONE;
        end else if (p_inf_s) begin
          rx_d = qx_q; ry_d = qy_q; err_d = 1'b0; state_d = S_DONE;
        end else if (q_inf_s) begin
          rx_d = px_q; ry_d = py_q; err_d = 1'b0; state_d = S_DONE;
        end else if (same_x_s && (mod_add(py_q, qy_q) == ZERO)) begin
          rx_d = ZERO; ry_d = ZERO; err_d = 1'b0; state_d = S_DONE;
        end else if (same_x_s && (py_q == qy_q)) begin
          mul_a_d = px_q; mul_b_d = px_q; acc_d = ZERO; mul_cnt_d = MUL_LEN;
          state_d = S_NUM_D;
        end else begin
          state_d = S_NUM_A;
        end
      end
      S_NUM_A: begin
        num_d = mod_sub(qy_q, py_q);
        u_d   = mod_sub(qx_q, px_q);
        v_d   = P;
        x1_d  = ONE;
        x2_d  = ZERO;
        state_d = S_INV;
      end
      S_NUM_D: begin
        if (mul_cnt_q != CNT_ZERO) begin
          acc_d = mul_step_s; mul_a_d = mul_a_q << 1'b1; mul_cnt_d = mul_cnt_q - CNT_ONE;
        end else begin
          num_d = mod_add(mod_add(mod_add(acc_q, acc_q), acc_q), A);
          u_d   = mod_add(py_q, py_q);
          v_d   = P;
          x1_d  = ONE;
          x2_d  = ZERO;
          state_d = S_INV;
        end
      end
      // Invariants: x1*den == u and x2*den == v (mod P); every step at least halves u*v.
      S_INV: begin
        if (u_q == ZERO) begin
          rx_d = ZERO; ry_d = ZERO; err_d = 1'b0; state_d = S_DONE;
        end else if (u_q == ONE) begin
          mul_a_d = num_q; mul_b_d = x1_q; acc_d = ZERO; mul_cnt_d = MUL_LEN; state_d = S_LAM;
        end else if (v_q == ONE) begin
          mul_a_d = num_q; mul_b_d = x2_q; acc_d = ZERO; mul_cnt_d = MUL_LEN; state_d = S_LAM;
        end else if (!u_q[0]) begin
          u_d = u_q >> 1'b1; x1_d = mod_half(x1_q);
        end else if (!v_q[0]) begin
          v_d = v_q >> 1'b1; x2_d = mod_half(x2_q);
        end else if (u_q > v_q) begin
          u_d = (u_q - v_q) >> 1'b1; x1_d = mod_half(mod_sub(x1_q, x2_q));
        end else begin
          v_d = (v_q - u_q) >> 1'b1; x2_d = mod_half(mod_sub(x2_q, x1_q));
        end
      end
      S_LAM: begin
        acc_d = mul_step_s; mul_a_d = mul_a_q << 1'b1; mul_cnt_d = mul_cnt_q - CNT_ONE;
        if (mul_cnt_q == CNT_ONE) begin
          lam_d = mul_step_s; mul_a_d = mul_step_s; mul_b_d = mul_step_s;
          acc_d = ZERO; mul_cnt_d = MUL_LEN; state_d = S_X3;
        end else begin
          state_d = S_LAM;
        end
      end
      S_X3: begin
        if (mul_cnt_q != CNT_ZERO) begin
          acc_d = mul_step_s; mul_a_d = mul_a_q << 1'b1; mul_cnt_d = mul_cnt_q - CNT_ONE;
        end else begin
          x3_d = x3_s; mul_a_d = lam_q; mul_b_d = mod_sub(px_q, x3_s);
          acc_d = ZERO; mul_cnt_d = MUL_LEN; state_d = S_Y3;
        end
      end
      S_Y3: begin
        if (mul_cnt_q != CNT_ZERO) begin
          acc_d = mul_step_s; mul_a_d = mul_a_q << 1'b1; mul_cnt_d = mul_cnt_q - CNT_ONE;
        end else begin
          rx_d = x3_q; ry_d = mod_sub(acc_q, py_q); err_d = 1'b0; state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      px_q        <= ZERO;
      py_q        <= ZERO;
      qx_q        <= ZERO;
      qy_q        <= ZERO;
      num_q       <= ZERO;
      lam_q       <= ZERO;
      x3_q        <= ZERO;
      u_q         <= ZERO;
      v_q         <= ZERO;
      x1_q        <= ZERO;
      x2_q        <= ZERO;
      acc_q       <= ZERO;
      mul_a_q     <= ZERO;
      mul_b_q     <= ZERO;
      mul_cnt_q   <= CNT_ZERO;
      rx_q        <= ZERO;
      ry_q        <= ZERO;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      num_q       <= num_d;
      lam_q       <= lam_d;
      x3_q        <= x3_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      acc_q       <= acc_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_cnt_q   <= mul_cnt_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      err_q       <= err_d;
      out_valid_q <= (state_d == S_DONE);
      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rx        = rx_q;
  assign ry        = ry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ec_point_adder_seq.sv
// Bench for ec_point_adder_seq on the toy curve y^2 = x^3 + 2x + 2 over GF(17).
// Latency is counted in rising edges, the accept edge being edge 1.
module tb_ec_point_adder_seq;
  localparam int W  = 5;
  localparam int PM = 17;
  localparam int AC = 2;
  localparam int LIM = 200;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [W-1:0] px, py, qx, qy, rx, ry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ec_point_adder_seq #(.WIDTH(W), .P(5'd17), .A(5'd2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .px(px), .py(py), .qx(qx), .qy(qy),
    .out_valid(out_valid), .out_ready(out_ready),
    .rx(rx), .ry(ry), .err(err), .busy(busy)
  );

  typedef struct {
    int ax; int ay; int bx; int by;
    int erx; int ery; int eerr; int kind;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int md(input int v);
    return ((v % PM) + PM) % PM;
  endfunction

  // Inverse by Fermat's little theorem, independent of the hardware algorithm.
  function automatic int minv(input int a);
    int r = 1;
    for (int k = 0; k < PM - 2; k++) r = md(r * a);
    return r;
  endfunction

  function automatic int bound(input int kind);
    return (kind == 2) ? (7 + 6 * W) : (6 + 5 * W);
  endfunction

  task automatic ref_model(input int ax, input int ay, input int bx, input int by,
                           output int erx, output int ery, output int eerr, output int kind);
    int lam;
    erx = 0; ery = 0; eerr = 0; kind = 0; lam = 0;
    if (ax >= PM || ay >= PM || bx >= PM || by >= PM) eerr = 1;
    else if (ax == 0 && ay == 0) begin erx = bx; ery = by; end
    else if (bx == 0 && by == 0) begin erx = ax; ery = ay; end
    else if (ax == bx && md(ay + by) == 0) begin erx = 0; ery = 0; end
    else begin
      if (ax == bx) begin kind = 2; lam = md(md(3 * ax * ax + AC) * minv(md(2 * ay))); end
      else begin kind = 1; lam = md(md(by - ay) * minv(md(bx - ax))); end
      erx = md(lam * lam - ax - bx);
      ery = md(lam * (ax - erx) - ay);
    end
  endtask

  task automatic accept(input int ax, input int ay, input int bx, input int by);
    int guard = 0;
    int r;
    while (!in_ready && guard < LIM) begin @(posedge clk); #1; guard++; end
    chk("in_ready_wait", int'(in_ready), 1);
    px = ax[W-1:0]; py = ay[W-1:0]; qx = bx[W-1:0]; qy = by[W-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r = $urandom;
    px = r[4:0]; py = r[9:5]; qx = r[14:10]; qy = r[19:15];
  endtask

  task automatic do_op(input int ax, input int ay, input int bx, input int by,
                       output int grx, output int gry, output int gerr, output int glat);
    accept(ax, ay, bx, by);
    glat = 1;
    chk("busy_after_accept", int'(busy), 1);
    chk("in_ready_busy", int'(in_ready), 0);
    while (!out_valid && glat < LIM) begin @(posedge clk); #1; glat++; end
    chk("out_valid_timeout", int'(out_valid), 1);
    grx = int'(rx); gry = int'(ry); gerr = int'(err);
  endtask

  task automatic consume(input int hold_rx, input int hold_ry);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_consume", int'(in_ready), 1);
    chk("out_valid_after_consume", int'(out_valid), 0);
    chk("rx_hold_after_consume", int'(rx), hold_rx);
    chk("ry_hold_after_consume", int'(ry), hold_ry);
  endtask

  initial begin
    int grx, gry, gerr, glat, erx, ery, eerr, kind, bad;
    int ax, ay, bx, by, sel;

    vecs[0] = '{5, 1, 6, 3, 10, 6, 0, 1};
    vecs[1] = '{5, 1, 5, 1, 6, 3, 0, 2};
    vecs[2] = '{10, 6, 10, 6, 16, 13, 0, 2};
    vecs[3] = '{0, 0, 5, 1, 5, 1, 0, 0};
    vecs[4] = '{5, 1, 0, 0, 5, 1, 0, 0};
    vecs[5] = '{5, 1, 5, 16, 0, 0, 0, 0};
    vecs[6] = '{17, 1, 6, 3, 0, 0, 1, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{3, 0, 3, 0, 0, 0, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    px = '0; py = '0; qx = '0; qy = '0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_rx", int'(rx), 0);
    chk("rst_ry", int'(ry), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_out_valid", int'(out_valid), 0);
    chk("idle_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by, grx, gry, gerr, glat);
      chk($sformatf("vec%0d_rx", i), grx, vecs[i].erx);
      chk($sformatf("vec%0d_ry", i), gry, vecs[i].ery);
      chk($sformatf("vec%0d_err", i), gerr, vecs[i].eerr);
      if (vecs[i].kind == 0) chk($sformatf("vec%0d_latency", i), glat, 2);
      else chk($sformatf("vec%0d_latency_bound(lat=%0d)", i, glat), (glat <= bound(vecs[i].kind)) ? 1 : 0, 1);
      consume(vecs[i].erx, vecs[i].ery);
    end

    // Back-pressure: result must stay put for 20 cycles.
    do_op(5, 1, 6, 3, grx, gry, gerr, glat);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rx != 5'd10 || ry != 5'd6 || err || in_ready || !out_valid) bad++;
    end
    chk("backpressure_stable_violations", bad, 0);
    chk("backpressure_rx", int'(rx), 10);
    consume(10, 6);

    // Abort inside the inverter via asynchronous reset.
    accept(5, 1, 6, 3);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_rx", int'(rx), 0);
    chk("abort_ry", int'(ry), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_stale_result", int'(out_valid), 0);
    do_op(5, 1, 6, 3, grx, gry, gerr, glat);
    chk("after_abort_rx", grx, 10);
    chk("after_abort_ry", gry, 6);
    consume(10, 6);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ax = $urandom_range(0, PM - 1); ay = $urandom_range(0, PM - 1);
      bx = $urandom_range(0, PM - 1); by = $urandom_range(0, PM - 1);
      if (sel == 0) begin bx = ax; by = ay; end
      else if (sel == 1) begin bx = ax; by = md(PM - ay); end
      else if (sel == 2) begin ax = 0; ay = 0; end
      else if (bx == ax) by = ay;
      if (sel == 3) begin
        case ($urandom_range(0, 3))
          0: ax = $urandom_range(PM, 31);
          1: ay = $urandom_range(PM, 31);
          2: bx = $urandom_range(PM, 31);
          default: by = $urandom_range(PM, 31);
        endcase
      end
      ref_model(ax, ay, bx, by, erx, ery, eerr, kind);
      do_op(ax, ay, bx, by, grx, gry, gerr, glat);
      chk($sformatf("rnd%0d_rx(%0d,%0d)+(%0d,%0d)", i, ax, ay, bx, by), grx, erx);
      chk($sformatf("rnd%0d_ry", i), gry, ery);
      chk($sformatf("rnd%0d_err", i), gerr, eerr);
      if (kind == 0) chk($sformatf("rnd%0d_latency", i), glat, 2);
      else chk($sformatf("rnd%0d_latency_bound(lat=%0d)", i, glat), (glat <= bound(kind)) ? 1 : 0, 1);
      consume(erx, ery);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
